// File: rtl/sobel_pkg.sv
// Shared definitions for the streaming Sobel edge detector: output mode
// encodings, kernel weights and the internal magnitude width rule.
package sobel_pkg;

  // Output selection, latched once per frame
  typedef enum logic {
    MODE_BIN = 1'b0,
    MODE_MAG = 1'b1
  } sobel_mode_e;

  // Sobel kernel weights: outer taps and centre tap of each difference row
  localparam int K_EDGE   = 1;
  localparam int K_CENTRE = 2;

  // Guard bits so that |Gx|+|Gy| (at most 8 * pixel max) never overflows
  localparam int MAG_GUARD = 3;

  function automatic int mag_width(input int pix_w);
    return pix_w + MAG_GUARD;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-line history for the 3x3 window. lb0 holds the previous image line and
// lb1 the line before that, both indexed by the current column. Reads are
// combinational so the old contents are seen before the same-address write.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(IMG_W)-1:0] col,
  input  logic [PIX_W-1:0]         pix,
  output logic [PIX_W-1:0]         prev1_pix,
  output logic [PIX_W-1:0]         prev2_pix
);

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  assign prev1_pix = lb0[col];
  assign prev2_pix = lb1[col];

  // Age the column by one line on every accepted pixel; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector. Accepts raster-order pixels through a
// valid/ready handshake, keeps a 3x3 window fed from two line buffers and
// emits one result per interior pixel through a single output register.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter  int PIX_W = 8,
  parameter  int IMG_W = 64,
  parameter  int IMG_H = 64,
  localparam int MAG_W = mag_width(PIX_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic [MAG_W-1:0] thresh,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_last,
  output logic             frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST_OUT = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_FIRST_OUT = ROW_W'(2);

  localparam logic [MAG_W-1:0]        PIX_MAX  = MAG_W'((1 << PIX_W) - 1);
  localparam logic signed [MAG_W-1:0] W_EDGE   = MAG_W'(K_EDGE);
  localparam logic signed [MAG_W-1:0] W_CENTRE = MAG_W'(K_CENTRE);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic [MAG_W-1:0] thresh_q;
  sobel_mode_e      mode_q;

  // win[r][c]: r = 0 top .. 2 bottom, c = 0 left .. 2 right (newest column)
  logic [PIX_W-1:0] win     [3][3];
  logic [PIX_W-1:0] win_nxt [3][3];

  logic [PIX_W-1:0] prev1_pix;
  logic [PIX_W-1:0] prev2_pix;

  logic accept;
  logic frame_start;
  logic produce;
  logic is_last;

  logic signed [MAG_W-1:0] p [9];
  logic signed [MAG_W-1:0] gx;
  logic signed [MAG_W-1:0] gy;
  logic [MAG_W-1:0]        abs_gx;
  logic [MAG_W-1:0]        abs_gy;
  logic [MAG_W-1:0]        mag;
  logic [PIX_W-1:0]        result;

  assign in_ready    = !out_valid | out_ready;
  assign accept      = in_valid & in_ready;
  assign frame_start = (row == '0) && (col == '0);
  assign produce     = accept && (row >= ROW_FIRST_OUT) && (col >= COL_FIRST_OUT);
  assign is_last     = (row == ROW_LAST) && (col == COL_LAST);

  sobel_line_buf #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (accept),
    .col       (col),
    .pix       (in_pix),
    .prev1_pix (prev1_pix),
    .prev2_pix (prev2_pix)
  );

  // Window as it will look after this accept: shift left, append the new column
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win[r][1];
      win_nxt[r][1] = win[r][2];
      win_nxt[r][2] = '0;
    end
    win_nxt[0][2] = prev2_pix;
    win_nxt[1][2] = prev1_pix;
    win_nxt[2][2] = in_pix;
  end

  // Zero-extend the nine taps (row-major p0..p8) and form both gradients
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      p[i] = $signed({{(MAG_W - PIX_W){1'b0}}, win_nxt[i / 3][i % 3]});
    end
    gx = (W_EDGE * p[2] + W_CENTRE * p[5] + W_EDGE * p[8])
       - (W_EDGE * p[0] + W_CENTRE * p[3] + W_EDGE * p[6]);
    gy = (W_EDGE * p[6] + W_CENTRE * p[7] + W_EDGE * p[8])
       - (W_EDGE * p[0] + W_CENTRE * p[1] + W_EDGE * p[2]);
  end

  // Magnitude and per-frame output formatting (threshold or saturate)
  always_comb begin
    abs_gx = gx[MAG_W-1] ? MAG_W'(-gx) : MAG_W'(gx);
    abs_gy = gy[MAG_W-1] ? MAG_W'(-gy) : MAG_W'(gy);
    mag    = abs_gx + abs_gy;
    result = '0;
    if (mode_q == MODE_MAG) begin
      result = (mag > PIX_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
    end else begin
      result = (mag > thresh_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    end
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Threshold and mode are frozen for the whole frame at its first pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thresh_q <= '0;
      mode_q   <= MODE_BIN;
    end else if (accept && frame_start) begin
      thresh_q <= thresh;
      mode_q   <= sobel_mode_e'(mode);
    end
  end

  // 3x3 window advances one column per accepted pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= win_nxt[r][c];
        end
      end
    end
  end

  // Single output stage; reloads in the same cycle a held result is taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_last  <= 1'b0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_pix   <= result;
      out_last  <= is_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle pulse after the final result of a frame is taken downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid & out_ready & out_last;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x8 image: flat, vertical step and
// diagonal ramp frames in both modes, output stalls, threshold latching and
// a mid-frame reset. Expected results come from hand-derived gradients.
module tb_sobel_stream;
  import sobel_pkg::*;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int MAG_W = mag_width(PIX_W);
  localparam int N_PIX = IMG_W * IMG_H;
  localparam int N_OUT = (IMG_W - 2) * (IMG_H - 2);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix = '0;
  logic [MAG_W-1:0] thresh = '0;
  logic             mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PIX_W-1:0] out_pix;
  logic             out_last;
  logic             frame_done;

  int total = 0;
  int bad   = 0;
  int frame_no = 0;

  sobel_stream #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pix     (in_pix),
    .thresh     (thresh),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pix    (out_pix),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Test images: 0 flat 100, 1 vertical step 0/200 at col 4,
  // 2 ramp 70-10*col+3*row, otherwise flat 50
  function automatic logic [PIX_W-1:0] pixAt(input int pat, input int r, input int c);
    case (pat)
      0:       return 8'd100;
      1:       return (c >= 4) ? 8'd200 : 8'd0;
      2:       return 8'(70 - 10 * c + 3 * r);
      default: return 8'd50;
    endcase
  endfunction

  // Hand-derived |Gx|+|Gy| at interior centre (r,c):
  // step -> Gx = 4*200 where the window straddles cols 3/4;
  // ramp -> |Gx| = 4*10*2 = 80, |Gy| = 4*3*2 = 24
  function automatic int magAt(input int pat, input int c);
    case (pat)
      1:       return (c == 3 || c == 4) ? 800 : 0;
      2:       return 104;
      default: return 0;
    endcase
  endfunction

  function automatic logic [PIX_W-1:0] expPix(input int mag, input logic md, input int th);
    if (md) return (mag > 255) ? 8'd255 : 8'(mag);
    return (mag > th) ? 8'hFF : 8'h00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s frame=%0d observed=%0d expected=%0d",
             tag, frame_no, observed, expected);
    end
  endtask

  // Stream one full frame and check every output, the stall behaviour,
  // out_last placement, output latency and the single frame_done pulse
  task automatic applyStimulus(input int pat, input logic md, input int th0,
                               input int th1, input bit stall);
    int   in_idx = 0;
    int   out_idx = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    bit   first_seen = 0;
    bit   holding = 0;
    logic [PIX_W-1:0] held = '0;
    frame_no++;
    mode   = md;
    thresh = MAG_W'(th0);
    while ((in_idx < N_PIX || out_idx < N_OUT) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (frame_done) done_cnt++;
      out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid  = (in_idx < N_PIX);
      in_pix    = in_valid ? pixAt(pat, in_idx / IMG_W, in_idx % IMG_W) : '0;
      if (in_idx >= 6) thresh = MAG_W'(th1);
      #1;
      if (stall) checkOutput("in_ready", 32'(in_ready), 32'(!out_valid | out_ready));
      if (holding) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_hold", 32'(out_pix), 32'(held));
      end
      holding = 0;
      if (out_valid && !first_seen) begin
        first_seen = 1;
        checkOutput("first_valid_accepts", 32'(in_idx), 32'd19);
      end
      if (out_valid) begin
        if (out_ready) begin
          checkOutput("out_pix",
                      32'(out_pix),
                      32'(expPix(magAt(pat, out_idx % (IMG_W - 2) + 1), md, th0)));
          checkOutput("out_last", 32'(out_last), 32'(out_idx == N_OUT - 1));
          out_idx++;
        end else begin
          held    = out_pix;
          holding = 1;
        end
      end
      if (in_valid && in_ready) in_idx++;
      @(posedge clk);
    end
    checkOutput("in_count", 32'(in_idx), 32'(N_PIX));
    checkOutput("out_count", 32'(out_idx), 32'(N_OUT));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (frame_done) done_cnt++;
    end
    checkOutput("frame_done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("idle_after_frame", 32'(out_valid), 32'd0);
  endtask

  // Push a partial frame with no checking, used before a mid-frame reset
  task automatic sendPixels(input int pat, input int n);
    int sent = 0;
    int cyc = 0;
    while (sent < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_pix    = pixAt(pat, sent / IMG_W, sent % IMG_W);
      #1;
      if (in_ready) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_pix", 32'(out_pix), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState();
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] flat frame, magnitude mode");
    applyStimulus(0, 1'b1, 0, 0, 1'b0);

    $display("[TB] vertical step, magnitude mode");
    applyStimulus(1, 1'b1, 0, 0, 1'b0);

    $display("[TB] vertical step, binary mode, thresholds 799 and 800");
    applyStimulus(1, 1'b0, 799, 799, 1'b0);
    applyStimulus(1, 1'b0, 800, 800, 1'b0);

    $display("[TB] ramp, magnitude mode (negative Gx plus positive Gy)");
    applyStimulus(2, 1'b1, 0, 0, 1'b0);

    $display("[TB] vertical step with random output stalls");
    applyStimulus(1, 1'b1, 0, 0, 1'b1);

    $display("[TB] threshold changed mid-frame applies from next frame");
    applyStimulus(2, 1'b0, 103, 104, 1'b0);
    applyStimulus(2, 1'b0, 104, 104, 1'b0);

    $display("[TB] reset after 20 pixels, then flat 50 frame");
    sendPixels(1, 20);
    reset = 1'b0;
    @(negedge clk);
    checkResetState();
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(3, 1'b1, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
